// File: rtl/fp_mul_booth_seq_if.sv
// Operand/result handshake bundle for the iterative FP mantissa multiplier.
// The master drives operands and out_ready; the slave (the multiplier) drives results.
interface fp_mul_booth_seq_if #(
    parameter int unsigned FRC_W = 23,
    parameter int unsigned EXP_W = 8
);
    localparam int unsigned FP_W   = 1 + EXP_W + FRC_W;
    localparam int unsigned PROD_W = 2 * (FRC_W + 1);
    localparam int unsigned ES_W   = EXP_W + 2;

    logic              in_valid;
    logic              in_ready;
    logic [FP_W-1:0]   fp_X;
    logic [FP_W-1:0]   fp_Y;
    logic [2:0]        r_mode;
    logic              out_valid;
    logic              out_ready;
    logic [PROD_W-1:0] frc_Z_full;
    logic              sign_Z;
    logic [ES_W-1:0]   exp_sum;
    logic [2:0]        r_mode_o;
    logic              z_zero;
    logic              z_inf;
    logic              z_nan;

    modport master (
        output in_valid, fp_X, fp_Y, r_mode, out_ready,
        input  in_ready, out_valid, frc_Z_full, sign_Z, exp_sum, r_mode_o,
               z_zero, z_inf, z_nan
    );

    modport slave (
        input  in_valid, fp_X, fp_Y, r_mode, out_ready,
        output in_ready, out_valid, frc_Z_full, sign_Z, exp_sum, r_mode_o,
               z_zero, z_inf, z_nan
    );
endinterface

// File: rtl/fp_mul_booth_seq.sv
// Iterative radix-4 Booth mantissa multiplier for single-precision FP multiply.
// Accepts one operand pair, retires one Booth digit per cycle for 13 cycles, then
// presents the raw 48-bit mantissa product with sign, exponent sum and special flags.
module fp_mul_booth_seq #(
    parameter int unsigned FRC_W = 23,
    parameter int unsigned EXP_W = 8,
    parameter int unsigned BIAS  = 127
) (
    input logic               clk,
    input logic               rst,
    fp_mul_booth_seq_if.slave bus
);
    localparam int unsigned MANT_W = FRC_W + 1;
    localparam int unsigned PROD_W = 2 * MANT_W;
    localparam int unsigned ACC_W  = PROD_W + 4;
    // Multiplier is {2'b00, hidden, fraction, 1'b0}; the appended zero seeds digit 0.
    localparam int unsigned MUL_W  = MANT_W + 3;
    localparam int unsigned N_ITER = (MUL_W - 1) / 2;
    localparam int unsigned ES_W   = EXP_W + 2;
    localparam logic [3:0]  LastCnt = 4'(N_ITER - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  mcand_q, mcand_d;
    logic [MUL_W-1:0]  mplier_q, mplier_d;
    logic [3:0]        cnt_q, cnt_d;

    // Operand attributes captured at accept, published with the product.
    logic              sign_q, sign_d;
    logic [ES_W-1:0]   exp_q, exp_d;
    logic [2:0]        rm_q, rm_d;
    logic              zero_q, zero_d;
    logic              inf_q, inf_d;
    logic              nan_q, nan_d;

    // Result registers; only loaded on the final Booth step.
    logic [PROD_W-1:0] frc_o_q, frc_o_d;
    logic              sign_o_q, sign_o_d;
    logic [ES_W-1:0]   exp_o_q, exp_o_d;
    logic [2:0]        rm_o_q, rm_o_d;
    logic              zero_o_q, zero_o_d;
    logic              inf_o_q, inf_o_d;
    logic              nan_o_q, nan_o_d;

    logic [EXP_W-1:0]  ex, ey, ex_eff, ey_eff;
    logic [FRC_W-1:0]  fx, fy;
    logic              hx, hy;
    logic              x_sub, y_sub, x_max, y_max, x_inf, y_inf, x_nan, y_nan;
    logic              z_nan_c, z_inf_c, z_zero_c;
    logic [ES_W-1:0]   exp_sum_c;
    logic [ACC_W-1:0]  pp;

    // Field decode and special-case classification of the incoming operands.
    always_comb begin
        ex        = bus.fp_X[FRC_W +: EXP_W];
        ey        = bus.fp_Y[FRC_W +: EXP_W];
        fx        = bus.fp_X[FRC_W-1:0];
        fy        = bus.fp_Y[FRC_W-1:0];
        hx        = |ex;
        hy        = |ey;
        x_sub     = (ex == '0);
        y_sub     = (ey == '0);
        x_max     = &ex;
        y_max     = &ey;
        x_inf     = x_max && (fx == '0);
        y_inf     = y_max && (fy == '0);
        x_nan     = x_max && (fx != '0);
        y_nan     = y_max && (fy != '0);
        // Subnormals share the exponent of the smallest normal.
        ex_eff    = x_sub ? EXP_W'(1) : ex;
        ey_eff    = y_sub ? EXP_W'(1) : ey;
        exp_sum_c = {2'b00, ex_eff} + {2'b00, ey_eff} - ES_W'(BIAS);
        z_nan_c   = x_nan | y_nan | (x_inf & y_sub) | (y_inf & x_sub);
        z_inf_c   = (x_inf | y_inf) & ~z_nan_c;
        z_zero_c  = ((x_sub & ~y_max) | (y_sub & ~x_max)) & ~z_nan_c;
    end

    // Booth partial product from the low multiplier triplet; mcand_q is pre-shifted by 2i.
    always_comb begin
        pp = '0;
        unique case (mplier_q[2:0])
            3'b000, 3'b111: pp = '0;
            3'b001, 3'b010: pp = mcand_q;
            3'b011:         pp = mcand_q << 1;
            3'b100:         pp = -(mcand_q << 1);
            3'b101, 3'b110: pp = -mcand_q;
            default:        pp = '0;
        endcase
    end

    // Next-state logic: accept in idle, one digit per busy cycle, hold in done.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        rm_d     = rm_q;
        zero_d   = zero_q;
        inf_d    = inf_q;
        nan_d    = nan_q;
        frc_o_d  = frc_o_q;
        sign_o_d = sign_o_q;
        exp_o_d  = exp_o_q;
        rm_o_d   = rm_o_q;
        zero_o_d = zero_o_q;
        inf_o_d  = inf_o_q;
        nan_o_d  = nan_o_q;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    acc_d    = '0;
                    cnt_d    = '0;
                    mcand_d  = ACC_W'({hx, fx});
                    mplier_d = {2'b00, hy, fy, 1'b0};
                    sign_d   = bus.fp_X[EXP_W+FRC_W] ^ bus.fp_Y[EXP_W+FRC_W];
                    exp_d    = exp_sum_c;
                    rm_d     = bus.r_mode;
                    zero_d   = z_zero_c;
                    inf_d    = z_inf_c;
                    nan_d    = z_nan_c;
                    state_d  = StBusy;
                end
            end
            StBusy: begin
                acc_d    = acc_q + pp;
                mcand_d  = mcand_q << 2;
                mplier_d = mplier_q >> 2;
                cnt_d    = cnt_q + 4'd1;
                if (cnt_q == LastCnt) begin
                    // Final sum is non-negative and fits in PROD_W bits.
                    frc_o_d  = acc_d[PROD_W-1:0];
                    sign_o_d = sign_q;
                    exp_o_d  = exp_q;
                    rm_o_d   = rm_q;
                    zero_o_d = zero_q;
                    inf_o_d  = inf_q;
                    nan_o_d  = nan_q;
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            rm_q     <= '0;
            zero_q   <= 1'b0;
            inf_q    <= 1'b0;
            nan_q    <= 1'b0;
            frc_o_q  <= '0;
            sign_o_q <= 1'b0;
            exp_o_q  <= '0;
            rm_o_q   <= '0;
            zero_o_q <= 1'b0;
            inf_o_q  <= 1'b0;
            nan_o_q  <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            rm_q     <= rm_d;
            zero_q   <= zero_d;
            inf_q    <= inf_d;
            nan_q    <= nan_d;
            frc_o_q  <= frc_o_d;
            sign_o_q <= sign_o_d;
            exp_o_q  <= exp_o_d;
            rm_o_q   <= rm_o_d;
            zero_o_q <= zero_o_d;
            inf_o_q  <= inf_o_d;
            nan_o_q  <= nan_o_d;
        end
    end

    assign bus.in_ready   = (state_q == StIdle);
    assign bus.out_valid  = (state_q == StDone);
    assign bus.frc_Z_full = frc_o_q;
    assign bus.sign_Z     = sign_o_q;
    assign bus.exp_sum    = exp_o_q;
    assign bus.r_mode_o   = rm_o_q;
    assign bus.z_zero     = zero_o_q;
    assign bus.z_inf      = inf_o_q;
    assign bus.z_nan      = nan_o_q;
endmodule

// File: tb/tb_fp_mul_booth_seq.sv
// Self-checking bench: directed vector table, randomized ops against a plain-arithmetic
// reference model, plus backpressure and mid-operation reset sequences.
module tb_fp_mul_booth_seq;
    logic clk;
    logic rst;

    fp_mul_booth_seq_if bus ();

    fp_mul_booth_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [2:0]  rm;
        logic [47:0] frc;
        logic        sign;
        logic [9:0]  es;
        logic        zero;
        logic        inf;
        logic        nan;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no end, required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Reference: straight integer product of the significands and the flag rules.
    function automatic vec_t model(input logic [31:0] x, input logic [31:0] y,
                                   input logic [2:0] rm);
        vec_t        r;
        int          ex, ey, es;
        logic [63:0] mx, my, prod;
        logic        xs, ys, xm, ym, xi, yi, xn, yn;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        mx = 64'(x[22:0]) + ((ex != 0) ? 64'h800000 : 64'h0);
        my = 64'(y[22:0]) + ((ey != 0) ? 64'h800000 : 64'h0);
        prod = mx * my;
        es = ((ex == 0) ? 1 : ex) + ((ey == 0) ? 1 : ey) - 127;
        xs = (ex == 0);
        ys = (ey == 0);
        xm = (ex == 255);
        ym = (ey == 255);
        xi = xm && (x[22:0] == 0);
        yi = ym && (y[22:0] == 0);
        xn = xm && (x[22:0] != 0);
        yn = ym && (y[22:0] != 0);
        r.x    = x;
        r.y    = y;
        r.rm   = rm;
        r.frc  = prod[47:0];
        r.sign = x[31] ^ y[31];
        r.es   = es[9:0];
        r.nan  = xn | yn | (xi & ys) | (yi & xs);
        r.inf  = (xi | yi) & ~r.nan;
        r.zero = ((xs & ~ym) | (ys & ~xm)) & ~r.nan;
        return r;
    endfunction

    task automatic check_result(input string tag, input vec_t e);
        check({tag, ".frc"},  64'(bus.frc_Z_full), 64'(e.frc));
        check({tag, ".sign"}, 64'(bus.sign_Z),     64'(e.sign));
        check({tag, ".exp"},  64'(bus.exp_sum),    64'(e.es));
        check({tag, ".rm"},   64'(bus.r_mode_o),   64'(e.rm));
        check({tag, ".flags"}, 64'({bus.z_zero, bus.z_inf, bus.z_nan}),
              64'({e.zero, e.inf, e.nan}));
    endtask

    // One full transaction with out_ready held high; checks latency and result.
    task automatic do_op(input string tag, input vec_t e);
        int cyc;
        @(negedge clk);
        bus.fp_X      = e.x;
        bus.fp_Y      = e.y;
        bus.r_mode    = e.rm;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        check({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        cyc = 0;
        while (!bus.out_valid && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, ".latency"}, 64'(cyc), 64'd13);
        check_result(tag, e);
        @(posedge clk);
        #1;
        check({tag, ".release"}, 64'({bus.out_valid, bus.in_ready}), 64'b01);
    endtask

    function automatic logic [31:0] rand_fp();
        logic [7:0]  e;
        logic [22:0] f;
        int          sel;
        sel = int'($urandom_range(0, 7));
        e = 8'($urandom);
        if (sel == 0) e = 8'h00;
        if (sel == 1) e = 8'hFF;
        f = 23'($urandom);
        if ($urandom_range(0, 3) == 0) f = '0;
        return {1'($urandom), e, f};
    endfunction

    vec_t        vecs[10];
    vec_t        e;
    logic [47:0] held;

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.fp_X      = '0;
        bus.fp_Y      = '0;
        bus.r_mode    = '0;

        //            x             y             rm      frc              s     es       z     i     n
        vecs[0] = '{32'h40400000, 32'h40400000, 3'b001, 48'h900000000000, 1'b0, 10'd129, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'h3FFFFFFF, 32'h3FFFFFFF, 3'b000, 48'hFFFFFE000001, 1'b0, 10'd127, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{32'h3F800000, 32'h3F800000, 3'b010, 48'h400000000000, 1'b0, 10'd127, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{32'hC0000000, 32'h40400000, 3'b011, 48'h600000000000, 1'b1, 10'd129, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{32'h00000001, 32'h3F800000, 3'b100, 48'h000000800000, 1'b0, 10'd1,   1'b1, 1'b0, 1'b0};
        vecs[5] = '{32'h7F800000, 32'h00000000, 3'b101, 48'h000000000000, 1'b0, 10'd129, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{32'h7FC00000, 32'h3F800000, 3'b110, 48'h600000000000, 1'b0, 10'd255, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{32'h7F800000, 32'h40000000, 3'b111, 48'h400000000000, 1'b0, 10'd256, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{32'h00000000, 32'h80000000, 3'b001, 48'h000000000000, 1'b1, 10'h383, 1'b1, 1'b0, 1'b0};
        vecs[9] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 3'b010, 48'hFFFFFE000001, 1'b0, 10'd381, 1'b0, 1'b0, 1'b0};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset.handshake", 64'({bus.in_ready, bus.out_valid}), 64'b10);
        check("reset.frc", 64'(bus.frc_Z_full), 64'd0);
        check("reset.misc", 64'({bus.sign_Z, bus.exp_sum, bus.r_mode_o, bus.z_zero,
                                 bus.z_inf, bus.z_nan}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i]);
        end

        for (int i = 0; i < 40; i++) begin
            e = model(rand_fp(), rand_fp(), 3'($urandom));
            do_op($sformatf("rand%0d", i), e);
        end

        // Backpressure: result held, new operands ignored while DONE.
        e = vecs[0];
        @(negedge clk);
        bus.fp_X      = e.x;
        bus.fp_Y      = e.y;
        bus.r_mode    = e.rm;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (13) @(posedge clk);
        #1;
        check("bp.valid", 64'(bus.out_valid), 64'd1);
        held = bus.frc_Z_full;
        check("bp.frc0", 64'(held), 64'h900000000000);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.fp_X     = 32'h3F800000;
            bus.fp_Y     = 32'h40000000;
            bus.r_mode   = 3'b111;
            bus.in_valid = k[0];
            @(posedge clk);
            #1;
            check($sformatf("bp%0d.hs", k), 64'({bus.out_valid, bus.in_ready}), 64'b10);
            check_result($sformatf("bp%0d", k), e);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp.release", 64'({bus.out_valid, bus.in_ready}), 64'b01);
        repeat (16) @(posedge clk);
        #1;
        check("bp.no_capture", 64'({bus.out_valid, bus.in_ready}), 64'b01);

        // Reset during BUSY iteration 6, then a normal op.
        @(negedge clk);
        bus.fp_X     = 32'h40000000;
        bus.fp_Y     = 32'h40000000;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid.hs", 64'({bus.out_valid, bus.in_ready}), 64'b01);
        check("rst_mid.frc", 64'(bus.frc_Z_full), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("rst_mid.idle", 64'({bus.out_valid, bus.in_ready}), 64'b01);
        do_op("after_rst", vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
